inst_fetch_responder: RTL
=========================

Name: inst_fetch_responder

Overview:
- Responder side of the instruction-fetch interface.
- Accepts fetch requests (byte PC) from the PC/fetch stage over a valid/ready handshake.
- Returns the addressed 32-bit instruction in order after a fixed pipeline latency.
- Owns the instruction store and exposes a program-load write port used by the bench or boot loader.
- Its inverted req_ready feeds the pipeline's hazard/stall input.

Parameters:
- DEPTH_LOG2, 8, log2 of instruction words stored (256 words = 1 KiB).
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  fetch request present
- req_addr  in  32  byte address of instruction
- req_ready  out  1  responder can accept a request this cycle
- flush  in  1  discard all in-flight responses (branch/jump redirect)
- load_en  in  1  program-load write strobe
- load_addr  in  32  byte address for load write
- load_data  in  32  instruction word to write
- rsp_valid  out  1  response valid (single-cycle pulse per request)
- rsp_addr  out  32  echo of accepted req_addr
- rsp_inst  out  32  instruction word
- fetch_err  out  1  error flag qualified by rsp_valid

Behaviour:
- Word index = addr[DEPTH_LOG2+1:2].
- Reset (rst==0 at posedge):
  - All pipeline valid bits cleared.
  - rsp_valid=0, rsp_addr=0, rsp_inst=0, fetch_err=0.
  - Memory contents are NOT cleared.
  - req_ready=0 during the reset cycle; it may assert the first cycle after rst returns high.
  - A reset mid-operation drops every in-flight request with no response.
- Acceptance:
  - req_ready = ~load_en while out of reset.
  - A request is accepted at a posedge where req_valid && req_ready.
  - One request per cycle maximum; fully pipelined, no backpressure on the response side.
- Read timing:
  - Memory is read in the accept cycle; address, data and error are captured into stage 1.
  - Data then shifts through LATENCY-1 further stages.
  - rsp_valid rises LATENCY cycles after the accept edge.
  - A later load to the same word does not alter an in-flight response.
- Ordering: responses come out strictly in acceptance order; back-to-back accepts give back-to-back rsp_valid pulses.
- Load:
  - On posedge with load_en=1, mem[load_addr index] <= load_data; load_addr[1:0] is ignored.
  - Load has priority over fetch: req_ready is low, so load and fetch never occur in the same cycle.
- Flush:
  - On posedge with flush=1, all stage valid bits clear, so no rsp_valid appears for requests accepted before that edge.
  - A request accepted on the same edge as flush IS kept; it is the redirect target.
- Misaligned request (req_addr[1:0]!=0): rsp_inst=32'h0000_0000 (NOP), fetch_err=1 alongside rsp_valid.
- Out-of-range request (req_addr[31:DEPTH_LOG2+2]!=0): index wraps modulo depth and fetch_err=0, unless the optional feature is enabled.
- Idle outputs:
  - rsp_valid=0.
  - rsp_inst and rsp_addr hold their last driven values.
  - fetch_err=0 whenever rsp_valid=0.

Optional Feature:
- Macro IMEM_RANGE_CHECK_EN.
- Defined:
  - An out-of-range request returns rsp_inst=0 with fetch_err=1.
  - An out-of-range load is dropped (no write, no wrap).
- Undefined: addresses wrap modulo depth for both read and load; fetch_err reflects misalignment only.

Test Plan:
- Reset, then load 0x2000_0001 to addr 0x0, 0x2000_0002 to addr 0x4, 0x2000_0003 to addr 0x8; fetch 0x0 -> rsp_valid exactly 2 cycles later (LATENCY=2), rsp_inst=0x2000_0001, rsp_addr=0x0, fetch_err=0.
- Fetch 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rsp_valid pulses carrying 0x2000_0001/2/3 in order.
- Fetch 0x0 and 0x4 back-to-back, then assert flush together with a request to 0x8 -> responses for 0x0/0x4 suppressed; only 0x8 returns 0x2000_0003.
- Fetch 0x6 -> rsp_inst=0x0, fetch_err=1; fetch 0x400 without the macro -> returns word 0 (0x2000_0001), fetch_err=0; with IMEM_RANGE_CHECK_EN -> rsp_inst=0, fetch_err=1.
- Hold load_en=1 while req_valid=1 -> req_ready=0 and no accept; fetch 0x4, then load 0xDEAD_BEEF to 0x4 next cycle -> response still 0x2000_0002.
- Fetch 0x0, drive rst=0 on the following edge -> no rsp_valid ever appears; all outputs 0; memory still holds 0x2000_0001.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// -----------------------------------------------------------------------------
// inst_fetch_responder
//
// Responder side of the instruction-fetch interface. Owns the instruction
// store, accepts byte-PC fetch requests over valid/ready and returns the
// addressed 32-bit word in acceptance order after a fixed LATENCY.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 32-bit words stored
//   LATENCY    - cycles from the accept edge to rsp_valid (1..4)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-low
//   req_valid  in   fetch request present
//   req_addr   in   byte address of instruction
//   req_ready  out  request can be accepted this cycle (low during load/reset)
//   flush      in   discard all in-flight responses (redirect)
//   load_en    in   program-load write strobe (wins over fetch)
//   load_addr  in   byte address of the load write
//   load_data  in   instruction word to write
//   rsp_valid  out  single-cycle pulse per accepted request
//   rsp_addr   out  echo of the accepted req_addr
//   rsp_inst   out  instruction word (0 on error)
//   fetch_err  out  misaligned (or out-of-range) access, qualified by rsp_valid
//
// Optional build macro:
//   IMEM_RANGE_CHECK_EN - out-of-range fetches return 0 with fetch_err=1 and
//                         out-of-range loads are dropped; otherwise addresses
//                         wrap modulo the depth.
// -----------------------------------------------------------------------------
module inst_fetch_responder #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_addr,
  output logic [31:0] rsp_inst,
  output logic        fetch_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_misaligned;
  logic                  w_rd_oor;
  logic                  w_ld_oor;
  logic                  w_rd_err;
  logic                  w_ld_we;
  logic [31:0]           w_rd_inst;
  logic                  w_accept;
  logic                  w_unused_bits;

  assign w_rd_idx     = req_addr[DEPTH_LOG2+1:2];
  assign w_ld_idx     = load_addr[DEPTH_LOG2+1:2];
  assign w_misaligned = |req_addr[1:0];
  assign w_rd_oor     = |req_addr[31:DEPTH_LOG2+2];
  assign w_ld_oor     = |load_addr[31:DEPTH_LOG2+2];

`ifdef IMEM_RANGE_CHECK_EN
  assign w_rd_err      = w_misaligned | w_rd_oor;
  assign w_ld_we       = load_en & ~w_ld_oor;
  assign w_unused_bits = ^load_addr[1:0];
`else
  assign w_rd_err      = w_misaligned;
  assign w_ld_we       = load_en;
  assign w_unused_bits = ^{load_addr[1:0], w_rd_oor, w_ld_oor};
`endif

  // Load owns the cycle; reset also holds ready low.
  assign req_ready = rst & ~load_en;
  assign w_accept  = req_valid & req_ready;

  // Store is never reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mem[w_ld_idx] <= load_data;
    end
  end

  // Read happens in the accept cycle, so a later load to the same word
  // cannot disturb a response already in flight.
  assign w_rd_inst = w_rd_err ? '0 : r_mem[w_rd_idx];

  logic [LATENCY-1:0] r_st_vld;
  logic [31:0]        r_st_addr [LATENCY];
  logic [31:0]        r_st_inst [LATENCY];
  logic [LATENCY-1:0] r_st_err;

  logic        r_rsp_vld;
  logic [31:0] r_rsp_addr;
  logic [31:0] r_rsp_inst;
  logic        r_rsp_err;

  // Stage 0 captures at the accept edge; the response register after the
  // last stage makes rsp_valid rise exactly LATENCY edges after accept.
  // Flush kills every older entry but never the request taken on its edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned s = 0; s < LATENCY; s++) begin
        r_st_vld[s]  <= 1'b0;
        r_st_addr[s] <= '0;
        r_st_inst[s] <= '0;
        r_st_err[s]  <= 1'b0;
      end
      r_rsp_vld  <= 1'b0;
      r_rsp_addr <= '0;
      r_rsp_inst <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_st_vld[0]  <= w_accept;
      r_st_addr[0] <= req_addr;
      r_st_inst[0] <= w_rd_inst;
      r_st_err[0]  <= w_rd_err;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        r_st_vld[s]  <= r_st_vld[s-1] & ~flush;
        r_st_addr[s] <= r_st_addr[s-1];
        r_st_inst[s] <= r_st_inst[s-1];
        r_st_err[s]  <= r_st_err[s-1];
      end
      r_rsp_vld <= r_st_vld[LATENCY-1] & ~flush;
      // Data outputs hold their last response while idle.
      if (r_st_vld[LATENCY-1] && !flush) begin
        r_rsp_addr <= r_st_addr[LATENCY-1];
        r_rsp_inst <= r_st_inst[LATENCY-1];
        r_rsp_err  <= r_st_err[LATENCY-1];
      end
    end
  end

  assign rsp_valid = r_rsp_vld;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_inst  = r_rsp_inst;
  assign fetch_err = r_rsp_vld & r_rsp_err;

endmodule
